// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ecc_pkg
// Description : Shared GF(2^163) field types, reduction constant, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ecc_pkg;

    localparam int FF_M = 163;

    typedef logic [FF_M-1:0] ff_elem_t;

    // Low-order terms of f(x) = x^163 + x^7 + x^6 + x^3 + 1 (x^163 implicit).
    localparam ff_elem_t FF_POLY = ff_elem_t'(8'hC9);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } sq_state_e;

endpackage : ecc_pkg
`default_nettype wire

// File: rtl/ff_squarer.sv
`default_nettype none
// ============================================================================
// Module      : ff_squarer
// Description : Combinational GF(2^163) squaring: bit spread then reduction.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_squarer
    import ecc_pkg::*;
(
    input  ff_elem_t a,
    output ff_elem_t y
);

    always_comb begin
        logic [2*FF_M-2:0] w_t;
        w_t = '0;
        for (int i = 0; i < FF_M; i++) begin
            w_t[2*i] = a[i];
        end
        // Fold from the top down; every fold target lies strictly below i.
        for (int i = 2*FF_M-2; i >= FF_M; i--) begin
            if (w_t[i]) begin
                w_t[i] = 1'b0;
                for (int j = 0; j < 8; j++) begin
                    if (FF_POLY[j]) begin
                        w_t[i-FF_M+j] = ~w_t[i-FF_M+j];
                    end
                end
            end
        end
        y = w_t[FF_M-1:0];
    end

endmodule : ff_squarer
`default_nettype wire

// File: rtl/ff_multi_squarer.sv
`default_nettype none
// ============================================================================
// Module      : ff_multi_squarer
// Description : Iterated Frobenius a^(2^k) in GF(2^163), 1 or 2 squarings/clk.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_multi_squarer
    import ecc_pkg::*;
#(
    parameter int SQ_PER_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  ff_elem_t         a,
    input  logic [CNT_W-1:0] k,
    output logic             busy,
    output logic             done,
    output ff_elem_t         result
);

    sq_state_e        r_state;
    sq_state_e        w_state_nxt;
    ff_elem_t         r_acc;
    ff_elem_t         w_acc_nxt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    ff_elem_t         w_sq1;
    ff_elem_t         w_sq2;
    logic             w_use2;

    ff_squarer u_sq1 (
        .a (r_acc),
        .y (w_sq1)
    );

    generate
        if (SQ_PER_CYC == 1) begin : g_one
            assign w_sq2 = w_sq1;
        end else if (SQ_PER_CYC == 2) begin : g_two
            ff_squarer u_sq2 (
                .a (w_sq1),
                .y (w_sq2)
            );
        end else begin : g_bad_param
            $error("ff_multi_squarer: SQ_PER_CYC must be 1 or 2");
        end
    endgenerate

    assign w_use2 = (SQ_PER_CYC == 2) && (r_rem >= CNT_W'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_rem <= '0;
        end else begin
            r_acc <= w_acc_nxt;
            r_rem <= w_rem_nxt;
        end
    end

    // FIN also accepts so that a held start yields one op per k+2 cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_rem_nxt   = r_rem;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (start) begin
                    w_acc_nxt   = a;
                    w_rem_nxt   = k;
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_rem == '0) begin
                    w_state_nxt = ST_FIN;
                end else if (w_use2) begin
                    w_acc_nxt = w_sq2;
                    w_rem_nxt = r_rem - CNT_W'(2);
                end else begin
                    w_acc_nxt = w_sq1;
                    w_rem_nxt = r_rem - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign busy   = (r_state == ST_RUN);
    assign done   = (r_state == ST_FIN);
    assign result = r_acc;

endmodule : ff_multi_squarer
`default_nettype wire
